// File: rtl/wb_gpio_responder_if.sv
// Wishbone classic slave-side bus bundle for the Caravel user-area GPIO responder.
// The management core is the master; the responder uses the slave modport.
interface wb_gpio_responder_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_gpio_responder.sv
// Wishbone classic responder exposing the 38 user IOs as memory-mapped registers,
// with synchronized inputs, rising-edge W1C status latching and an edge interrupt.
module wb_gpio_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          NUM_IO    = 38
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    wb_gpio_responder_if.slave    wbs,
    input  logic [NUM_IO-1:0]     io_in,
    output logic [NUM_IO-1:0]     io_out,
    output logic [NUM_IO-1:0]     io_oeb,
    output logic [2:0]            user_irq
);

    localparam int HI_W = NUM_IO - 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        for (int b = 0; b < 4; b++) begin
            byte_mask[8*b +: 8] = {8{sel[b]}};
        end
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        lane_merge = (old_v & ~byte_mask(sel)) | (new_v & byte_mask(sel));
    endfunction

    // HI registers only live in byte lane 0
    function automatic logic [HI_W-1:0] hi_merge(input logic [HI_W-1:0] old_v,
                                                 input logic [31:0]     new_v,
                                                 input logic            sel0);
        hi_merge = sel0 ? new_v[HI_W-1:0] : old_v;
    endfunction

    state_t              state_r, state_nxt_s;
    logic [NUM_IO-1:0]   out_r, oeb_r, en_r, stat_r;
    logic [NUM_IO-1:0]   sync1_r, sync_r, prev_r;
    logic [NUM_IO-1:0]   rise_s, clr_s;
    logic                irq_r;
    logic [31:0]         dat_o_r, rd_data_s, wr_dat_masked_s;
    logic [9:0]          reg_hit_s, wr_hit_s;
    logic [5:0]          word_s;
    logic                hit_s, req_s;
    logic                unused_adr_s;

    assign unused_adr_s    = &{1'b0, wbs.wbs_adr_i[1:0]};
    assign word_s          = wbs.wbs_adr_i[7:2];
    assign hit_s           = (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign req_s           = wbs.wbs_cyc_i & wbs.wbs_stb_i & hit_s & (state_r == ST_IDLE);
    assign wr_hit_s        = (req_s && wbs.wbs_we_i) ? reg_hit_s : 10'b0;
    assign wr_dat_masked_s = wbs.wbs_dat_i & byte_mask(wbs.wbs_sel_i);
    assign rise_s          = sync_r & ~prev_r;
    assign clr_s           = {(wr_hit_s[9] ? wr_dat_masked_s[HI_W-1:0] : {HI_W{1'b0}}),
                              (wr_hit_s[8] ? wr_dat_masked_s : 32'h0000_0000)};

    assign wbs.wbs_ack_o = (state_r == ST_ACK);
    assign wbs.wbs_dat_o = dat_o_r;
    assign io_out        = out_r;
    assign io_oeb        = oeb_r;
    assign user_irq      = {2'b00, irq_r};

    // Register decode: read mux and one-hot register select
    always_comb begin
        rd_data_s = 32'h0000_0000;
        reg_hit_s = 10'b0;
        case (word_s)
            6'h00: begin rd_data_s = out_r[31:0];                                reg_hit_s[0] = 1'b1; end
            6'h01: begin rd_data_s = {{(32-HI_W){1'b0}}, out_r[NUM_IO-1:32]};    reg_hit_s[1] = 1'b1; end
            6'h02: begin rd_data_s = oeb_r[31:0];                                reg_hit_s[2] = 1'b1; end
            6'h03: begin rd_data_s = {{(32-HI_W){1'b0}}, oeb_r[NUM_IO-1:32]};    reg_hit_s[3] = 1'b1; end
            6'h04: begin rd_data_s = sync_r[31:0];                               reg_hit_s[4] = 1'b1; end
            6'h05: begin rd_data_s = {{(32-HI_W){1'b0}}, sync_r[NUM_IO-1:32]};   reg_hit_s[5] = 1'b1; end
            6'h06: begin rd_data_s = en_r[31:0];                                 reg_hit_s[6] = 1'b1; end
            6'h07: begin rd_data_s = {{(32-HI_W){1'b0}}, en_r[NUM_IO-1:32]};     reg_hit_s[7] = 1'b1; end
            6'h08: begin rd_data_s = stat_r[31:0];                               reg_hit_s[8] = 1'b1; end
            6'h09: begin rd_data_s = {{(32-HI_W){1'b0}}, stat_r[NUM_IO-1:32]};   reg_hit_s[9] = 1'b1; end
            default: begin rd_data_s = 32'h0000_0000; reg_hit_s = 10'b0; end
        endcase
    end

    // Handshake next state: one ack cycle per accepted request, then a forced idle cycle
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    state_nxt_s = ST_ACK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACK:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Handshake state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Bus registers, input synchronizer, edge status and interrupt
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            out_r   <= {NUM_IO{1'b0}};
            oeb_r   <= {NUM_IO{1'b1}};
            en_r    <= {NUM_IO{1'b0}};
            stat_r  <= {NUM_IO{1'b0}};
            sync1_r <= {NUM_IO{1'b0}};
            sync_r  <= {NUM_IO{1'b0}};
            prev_r  <= {NUM_IO{1'b0}};
            irq_r   <= 1'b0;
            dat_o_r <= 32'h0000_0000;
        end else begin
            sync1_r <= io_in;
            sync_r  <= sync1_r;
            prev_r  <= sync_r;
            if (wr_hit_s[0]) out_r[31:0]        <= lane_merge(out_r[31:0], wbs.wbs_dat_i, wbs.wbs_sel_i);
            if (wr_hit_s[1]) out_r[NUM_IO-1:32] <= hi_merge(out_r[NUM_IO-1:32], wbs.wbs_dat_i, wbs.wbs_sel_i[0]);
            if (wr_hit_s[2]) oeb_r[31:0]        <= lane_merge(oeb_r[31:0], wbs.wbs_dat_i, wbs.wbs_sel_i);
            if (wr_hit_s[3]) oeb_r[NUM_IO-1:32] <= hi_merge(oeb_r[NUM_IO-1:32], wbs.wbs_dat_i, wbs.wbs_sel_i[0]);
            if (wr_hit_s[6]) en_r[31:0]         <= lane_merge(en_r[31:0], wbs.wbs_dat_i, wbs.wbs_sel_i);
            if (wr_hit_s[7]) en_r[NUM_IO-1:32]  <= hi_merge(en_r[NUM_IO-1:32], wbs.wbs_dat_i, wbs.wbs_sel_i[0]);
            // a new edge in the same cycle as its W1C clear keeps the bit set
            stat_r  <= (stat_r & ~clr_s) | rise_s;
            irq_r   <= |(stat_r & en_r);
            dat_o_r <= req_s ? rd_data_s : 32'h0000_0000;
        end
    end

endmodule
